front_spi_arbiter: RTL

// - N-channel arbiter/sequencer in front of the single shared front-panel SPI master.
// - Replaces the fixed LCD/switch 2-way CS mux with a round-robin scheduler for any number of panel devices (LCD, switch, LED driver, ...).
// - Latches each requestor's MOSI word, launches one SPI transfer and routes CS to the granted device only.
// - Returns the MISO word with a per-channel done pulse; enforces an inter-transfer gap and a transfer timeout.

---
 rtl/front_spi_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/front_spi_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared front-panel SPI master.
// Latches the granted channel's word, launches one transfer, routes CS and returns MISO with done/timeout status.
module front_spi_arbiter #(
   parameter int unsigned N_CH        = 2,
   parameter int unsigned DW          = 24,
   parameter int unsigned GAP_CYC     = 4,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [N_CH-1:0]      i_req,
   input  logic [N_CH*DW-1:0]   i_mosi_data,
   output logic [N_CH-1:0]      o_ack,
   output logic [N_CH-1:0]      o_done,
   output logic [DW-1:0]        o_miso_data,
   output logic [N_CH-1:0]      o_timeout_err,
   input  logic                 i_err_clear,
   output logic                 o_busy,
   output logic                 o_spi_start,
   output logic [DW-1:0]        o_mosi_data,
   input  logic [DW-1:0]        i_miso_data,
   input  logic                 i_spi_cs,
   output logic [N_CH-1:0]      o_cs_n
);

   localparam int unsigned PW     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned T_MAXC = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
   localparam int unsigned TW     = (T_MAXC > 0) ? $clog2(T_MAXC + 1) : 1;

   localparam logic [TW-1:0] GAP_V   = TW'(GAP_CYC);
   localparam logic [TW-1:0] TO_V    = TW'(TIMEOUT_CYC);
   localparam logic [TW-1:0] T_SAT   = TW'(T_MAXC);
   localparam logic [PW-1:0] PTR_RST = PW'(N_CH - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      XFER,
      GAP
   } state_t;

   // Completion and abort both leave through the same state.
   localparam state_t END_STATE = (GAP_CYC == 0) ? IDLE : GAP;

   state_t           state, state_nxt;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    grant;
   logic [PW-1:0]    gnt_idx;
   logic [PW-1:0]    cand_idx;
   logic             gnt_vld;
   logic [31:0]      cand;
   logic [TW-1:0]    timer;
   logic             cs_q;
   logic             cs_rise;
   logic             tmo_hit;
   logic [N_CH-1:0]  err_set;

   assign cs_rise = ~cs_q & i_spi_cs;
   assign tmo_hit = (TIMEOUT_CYC != 0) && (timer == TO_V);

   // First requester after the last grant, wrapping modulo N_CH.
   always_comb begin
      gnt_idx  = ptr;
      gnt_vld  = 1'b0;
      cand     = '0;
      cand_idx = '0;
      for (int unsigned i = 1; i <= N_CH; i++) begin
         cand     = (32'(ptr) + i) % N_CH;
         cand_idx = PW'(cand);
         if (!gnt_vld && i_req[cand_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand_idx;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (gnt_vld) state_nxt = START;
         START: begin
            if (!i_spi_cs)   state_nxt = XFER;
            else if (tmo_hit) state_nxt = END_STATE;
         end
         XFER:    if (cs_rise || tmo_hit) state_nxt = END_STATE;
         GAP:     if (timer == GAP_V) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state != IDLE);
      o_cs_n = '1;
      if (state == START || state == XFER) begin
         o_cs_n[grant] = i_spi_cs;
      end
   end

   // A cs rise coinciding with expiry counts as a normal completion.
   always_comb begin
      err_set = '0;
      if ((state == START && i_spi_cs && tmo_hit) ||
          (state == XFER && !cs_rise && tmo_hit)) begin
         err_set[grant] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ptr           <= PTR_RST;
         grant         <= '0;
         timer         <= '0;
         cs_q          <= 1'b1;
         o_ack         <= '0;
         o_done        <= '0;
         o_spi_start   <= 1'b0;
         o_mosi_data   <= '0;
         o_miso_data   <= '0;
         o_timeout_err <= '0;
      end else begin
         cs_q        <= i_spi_cs;
         o_ack       <= '0;
         o_done      <= '0;
         o_spi_start <= 1'b0;

         if (state_nxt != state) begin
            timer <= '0;
         end else if (state != IDLE && timer != T_SAT) begin
            timer <= timer + 1'b1;
         end

         if (state == IDLE && gnt_vld) begin
            ptr            <= gnt_idx;
            grant          <= gnt_idx;
            o_mosi_data    <= i_mosi_data[gnt_idx*DW +: DW];
            o_ack[gnt_idx] <= 1'b1;
            o_spi_start    <= 1'b1;
         end

         if (state == XFER && cs_rise) begin
            o_miso_data   <= i_miso_data;
            o_done[grant] <= 1'b1;
         end

         if (i_err_clear) begin
            o_timeout_err <= '0;
         end else begin
            o_timeout_err <= o_timeout_err | err_set;
         end
      end
   end

endmodule
